// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and constants for the instruction-memory loader.
//   state_t        : loader FSM states
//   HDR_BYTES      : bytes in the little-endian word-count header
//   BYTES_PER_WORD : stream bytes per 32-bit instruction word
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_assembler.sv
// -----------------------------------------------------------------------------
// imem_word_assembler
// Collects stream bytes into little-endian 32-bit words.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   i_clear        : synchronous clear of buffer and byte index (new load)
//   i_valid        : a byte is accepted this cycle
//   i_byte         : accepted byte
//   o_word_valid   : this cycle's byte completes a word (combinational)
//   o_word         : completed word {b3,b2,b1,b0}, valid with o_word_valid
// -----------------------------------------------------------------------------
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam int BUF_W = 8 * (BYTES_PER_WORD - 1);

  logic [IDX_W-1:0] r_idx;
  logic [BUF_W-1:0] r_buf;

  // New bytes enter at the top and shift down, so after three bytes the
  // buffer already holds {b2,b1,b0} and the fourth byte lands in [31:24].
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  // NOTE: the data buffer is cleared with the index only to keep outputs
  // deterministic; its contents are never used before four fresh bytes arrive.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_idx <= '0;
      r_buf <= '0;
    end else if (i_valid) begin
      r_idx <= r_idx + IDX_W'(1);
      r_buf <= {i_byte, r_buf[BUF_W-1:8]};
    end
  end

  assign o_word_valid = i_valid && (r_idx == IDX_W'(BYTES_PER_WORD - 1));
  assign o_word       = {i_byte, r_buf};

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Writer side of the instruction memory: receives a framed byte stream
// (2-byte LE word count N, N*4 LE instruction bytes[, checksum byte]) and
// writes words to sequential word addresses from 0 while holding the core.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds CSUM state, csum_err).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start                 : arms a load (IDLE only)
//   in_data/in_valid      : stream byte and its valid
//   in_ready              : loader accepts a byte (state-only)
//   we_en/we_addr/we_data : instruction memory write port (word address)
//   cpu_hold              : core held for the duration of a load
//   done                  : one-cycle pulse at completion
//   overflow              : sticky, frame had more words than DEPTH
//   busy                  : not IDLE
//   csum_err              : sticky checksum mismatch (feature only)
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              we_en,
  output logic [ADDR_W-1:0] we_addr,
  output logic [31:0]       we_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              overflow,
  output logic              busy
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic              csum_err
`endif
);

  localparam int LEN_W = 8 * HDR_BYTES;
  localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = CSUM;
`else
  localparam state_t END_STATE = DONE;
`endif

  state_t            r_state;
  state_t            w_next;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_word_cnt;
  logic              r_we_en;
  logic [ADDR_W-1:0] r_we_addr;
  logic [31:0]       r_we_data;
  logic              r_overflow;

  logic              w_accept;
  logic              w_arm;
  logic              w_word_valid;
  logic [31:0]       w_word;
  logic              w_last_word;
  logic              w_in_range;
  logic              w_len_zero;

  assign w_accept = in_valid && in_ready;
  assign w_arm    = (r_state == IDLE) && start;

  // Widened by one bit so cnt+1 cannot wrap for N = 65535.
  assign w_last_word = ({1'b0, r_word_cnt} + (LEN_W + 1)'(1)) == {1'b0, r_len};
  assign w_in_range  = {1'b0, r_word_cnt} < DEPTH_L;
  // Header high byte is still on in_data when the N==0 decision is made.
  assign w_len_zero  = ({in_data, r_len[7:0]} == '0);

  imem_word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_arm),
    .i_valid      ((r_state == DATA) && w_accept),
    .i_byte       (in_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  // NOTE: the default assignment first keeps this purely combinational;
  // any path that leaves w_next unassigned would infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)    w_next = LEN0;
      LEN0:    if (w_accept) w_next = LEN1;
      LEN1:    if (w_accept) w_next = w_len_zero ? END_STATE : DATA;
      DATA:    if (w_word_valid && w_last_word) w_next = END_STATE;
      CSUM:    if (w_accept) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    busy     = (r_state != IDLE);
    cpu_hold = (r_state != IDLE);
    case (r_state)
      LEN0, LEN1, DATA, CSUM: in_ready = 1'b1;
      DONE:                   done     = 1'b1;
      default:                ;
    endcase
  end

  // Header, word counter and write port. Words past DEPTH are counted but
  // never written so the address cannot wrap onto loaded code.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len      <= '0;
      r_word_cnt <= '0;
      r_we_en    <= 1'b0;
      r_we_addr  <= '0;
      r_we_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_we_en <= 1'b0;
      if (w_arm) begin
        r_len      <= '0;
        r_word_cnt <= '0;
        r_overflow <= 1'b0;
      end
      if ((r_state == LEN0) && w_accept) r_len[7:0]  <= in_data;
      if ((r_state == LEN1) && w_accept) r_len[15:8] <= in_data;
      if (w_word_valid) begin
        r_word_cnt <= r_word_cnt + LEN_W'(1);
        if (w_in_range) begin
          r_we_en   <= 1'b1;
          r_we_addr <= r_word_cnt[ADDR_W-1:0];
          r_we_data <= w_word;
        end else begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       r_csum_err;

  // Running XOR of data bytes only; header bytes are excluded.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_csum     <= '0;
      r_csum_err <= 1'b0;
    end else if (w_arm) begin
      r_csum     <= '0;
      r_csum_err <= 1'b0;
    end else if (w_accept) begin
      if (r_state == DATA) r_csum <= r_csum ^ in_data;
      if ((r_state == CSUM) && (in_data != r_csum)) r_csum_err <= 1'b1;
    end
  end

  assign csum_err = r_csum_err;
`endif

  assign we_en    = r_we_en;
  assign we_addr  = r_we_addr;
  assign we_data  = r_we_data;
  assign overflow = r_overflow;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. The memory itself is a word-indexed 32-bit array that the core reads combinationally by PC.
- Receives a byte stream over a valid/ready interface (host UART/debug bridge) and assembles little-endian 32-bit instruction words.
- Drives the instruction memory write port at sequential word addresses from 0.
- Holds the core (cpu_hold) for the whole load and pulses done when the program is in place.

Parameters:
- DEPTH, 256, number of 32-bit words in instruction memory.
- ADDR_W, 8, width of word address; must equal clog2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that arms a load; ignored unless in IDLE.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte.
- we_en  output  1  instruction memory write strobe.
- we_addr  output  ADDR_W  word address (memory index, not byte address).
- we_data  output  32  instruction word.
- cpu_hold  output  1  core stall/reset request while loading.
- done  output  1  one-cycle pulse at load completion.
- overflow  output  1  sticky: header word count exceeded DEPTH.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- One clock domain; reset is synchronous and active-high. Clock and reset ports are named clk and reset.
- Reset values: in_ready=0, we_en=0, we_addr=0, we_data=0, cpu_hold=0, done=0, overflow=0, busy=0; state=IDLE; byte counter=0; word counter=0.
- Byte transfer occurs only when in_valid && in_ready. in_ready is combinational from state only (high in LEN0, LEN1, DATA, CSUM), never from in_valid.
- Frame format: 2-byte little-endian word count N, then N×4 bytes (byte0 = instr[7:0] ... byte3 = instr[31:24]), then an optional checksum byte (see Optional Feature).
- State IDLE: start goes to LEN0, clears overflow and the counters, and sets cpu_hold=1.
- State LEN0: accepting a byte latches N[7:0] and goes to LEN1.
- State LEN1: accepting a byte latches N[15:8].
  - If N==0, go to DONE (or CSUM when the feature is enabled).
  - Otherwise go to DATA.
- State DATA: bytes fill a 4-byte shift buffer.
  - On acceptance of the 4th byte of word k, the next cycle has we_en=1, we_addr=k[ADDR_W-1:0], we_data={b3,b2,b1,b0}. Write latency is exactly 1 cycle; we_en is a single-cycle pulse.
  - Byte acceptance continues without bubbles during the write cycle.
  - After word N-1 is accepted, go to DONE (or CSUM).
- Overflow: words with index k >= DEPTH are consumed but not written (no we_en); overflow sets at the first such word and remains set until the next start. No address wrap-around.
- State DONE: lasts 1 cycle. done=1 in that cycle, coinciding with the final we_en. The next state is IDLE and cpu_hold drops to 0 on that next cycle.
- Behaviour of in_data with in_valid=0: ignored. No timeout; the loader waits indefinitely.
- start while busy: ignored.
- reset mid-load: returns to IDLE with cpu_hold=0 and the partial word discarded. Words already written remain in memory.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Enabled:
  - After the data (or after LEN1 when N==0), state CSUM accepts one byte and compares it with the XOR of all data bytes (header bytes excluded).
  - Extra port csum_err (output, 1), sticky until next start, set on mismatch.
  - done still pulses one cycle after the CSUM byte is accepted.
- Disabled: no CSUM state, no csum_err port; frame ends at the last data byte.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum (IDLE, LEN0, LEN1, DATA, CSUM, DONE);
  - the header byte count constant (2);
  - the bytes-per-word constant (4).
- One natural sub-module, imem_word_assembler: 4-byte shift buffer plus 2-bit byte index, producing word_valid and the word. The FSM, counters and write port stay in imem_loader.

Test Plan:
- Basic load: start, then bytes 02 00, 93 00 10 00, 33 01 31 00 → we_en at addr 0 data 0x00100093, then addr 1 data 0x00310133; done pulses with the second write; cpu_hold low the following cycle.
- N=0: start, bytes 00 00 → no we_en; done pulses 1 cycle after the second byte; overflow=0.
- Backpressure/gaps: same frame as basic load with in_valid toggled randomly → identical writes; in_ready low in IDLE/DONE; no byte accepted outside a handshake.
- Overflow: DEPTH=4, N=6 → writes to addr 0..3 only; overflow=1 from the 5th word; done still pulses after 24 data bytes; overflow clears on the next start.
- Reset mid-load: reset after 6 data bytes → state IDLE, cpu_hold=0, no further we_en; a fresh start/frame then loads correctly from addr 0.
- Checksum (IMEM_LOADER_CHECKSUM_EN): N=1, data 13 00 00 00, checksum 13 → csum_err=0; repeat with checksum 12 → csum_err=1, done still pulses.
